// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial MEM-stage load/store unit:
// funct3 encodings, FSM states and per-op byte count / alignment helpers.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    function automatic logic op_known(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic [2:0] byte_cnt(input logic [2:0] f3);
        case (f3)
            F3_LH, F3_LHU: return 3'd2;
            F3_LW:         return 3'd4;
            default:       return 3'd1;
        endcase
    endfunction

    // Store encodings alias the load ones, so one check covers both.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_LH, F3_LHU: return lo[0];
            F3_LW:         return lo != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_ext.sv
// Load result extender: maps funct3 and the little-endian assembled bytes
// to the write-back value (sign- or zero-extended).
module mem_lsu_ext
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = '0;
        case (funct3)
            F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   data = raw;
            F3_LBU:  data = {24'd0, raw[7:0]};
            F3_LHU:  data = {16'd0, raw[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Byte-serial load/store unit for the MEM stage. Optional misaligned-access
// trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int XLEN    = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              done,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              fault,
    output logic              stall
);

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t state_q, state_d;
    logic store_q, store_d;
    logic known_q, known_d;
    logic [2:0] f3_q, f3_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [4:0] rd_q, rd_d;
    logic [1:0] idx_q, idx_d;
    logic [31:0] result_q, result_d;

    logic [RAM_LAT-1:0]      cap_v_q, cap_v_d;
    logic [RAM_LAT-1:0][1:0] cap_idx_q, cap_idx_d;

    logic req_ready_q, req_ready_d;
    logic stall_q, stall_d;
    logic ram_en_q, ram_en_d;
    logic ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0] ram_dout_q, ram_dout_d;
    logic done_q, done_d;
    logic wb_we_q, wb_we_d;
    logic [4:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic fault_q, fault_d;

    logic        accept;
    logic        new_known;
    logic        new_misaligned;
    logic [2:0]  cnt;
    logic [1:0]  last_idx;
    logic [1:0]  nidx;
    logic        cap_fire;
    logic [1:0]  cap_k;
    logic [31:0] assembled;
    logic [31:0] ext_data;

    assign accept         = req_valid && req_ready_q;
    assign new_known      = op_known(req_we, req_funct3);
    assign new_misaligned = TRAP_EN && new_known && is_misaligned(req_funct3, req_addr[1:0]);
    assign cnt            = known_q ? byte_cnt(f3_q) : 3'd1;
    assign last_idx       = 2'(cnt - 3'd1);
    assign nidx           = idx_q + 2'd1;
    assign cap_fire       = cap_v_q[RAM_LAT-1];
    assign cap_k          = cap_idx_q[RAM_LAT-1];

    // Byte k read back RAM_LAT cycles after issue lands in lane k of the result.
    always_comb begin
        assembled = result_q;
        if (cap_fire)
            assembled[{cap_k, 3'b000} +: 8] = ram_din;
    end

    mem_lsu_ext u_ext (
        .funct3 (f3_q),
        .raw    (assembled),
        .data   (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        known_d     = known_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        idx_d       = idx_q;
        result_d    = assembled;
        req_ready_d = req_ready_q;
        stall_d     = stall_q;
        ram_en_d    = ram_en_q;
        ram_wr_d    = ram_wr_q;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        done_d      = 1'b0;
        wb_we_d     = 1'b0;
        fault_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;

        cap_v_d[0]   = ram_en_q && !ram_wr_q;
        cap_idx_d[0] = idx_q;
        for (int unsigned i = 1; i < RAM_LAT; i++) begin
            cap_v_d[i]   = cap_v_q[i-1];
            cap_idx_d[i] = cap_idx_q[i-1];
        end

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    f3_d    = req_funct3;
                    known_d = new_known;
                    store_d = req_we && new_known;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    if (new_misaligned) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        fault_d   = 1'b1;
                        wb_rd_d   = req_rd;
                        wb_data_d = '0;
                    end else begin
                        state_d     = ISSUE;
                        idx_d       = 2'd0;
                        result_d    = '0;
                        ram_en_d    = 1'b1;
                        ram_wr_d    = req_we && new_known;
                        ram_addr_d  = req_addr;
                        ram_dout_d  = req_wdata[7:0];
                        req_ready_d = 1'b0;
                        stall_d     = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (idx_q == last_idx) begin
                    ram_en_d = 1'b0;
                    ram_wr_d = 1'b0;
                    if (store_q) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        wb_rd_d     = rd_q;
                        wb_data_d   = '0;
                        req_ready_d = 1'b1;
                        stall_d     = 1'b0;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    idx_d      = nidx;
                    ram_addr_d = ram_addr_q + ADDR_W'(1);
                    ram_dout_d = wdata_q[{nidx, 3'b000} +: 8];
                end
            end
            DRAIN: begin
                if (cap_fire && cap_k == last_idx) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    wb_we_d     = known_q && (rd_q != 5'd0);
                    wb_rd_d     = rd_q;
                    wb_data_d   = known_q ? ext_data : '0;
                    req_ready_d = 1'b1;
                    stall_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            known_q     <= 1'b0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            idx_q       <= '0;
            result_q    <= '0;
            cap_v_q     <= '0;
            cap_idx_q   <= '0;
            req_ready_q <= 1'b1;
            stall_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_dout_q  <= '0;
            done_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            known_q     <= known_d;
            f3_q        <= f3_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            idx_q       <= idx_d;
            result_q    <= result_d;
            cap_v_q     <= cap_v_d;
            cap_idx_q   <= cap_idx_d;
            req_ready_q <= req_ready_d;
            stall_q     <= stall_d;
            ram_en_q    <= ram_en_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            done_q      <= done_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign stall     = stall_q;
    assign ram_en    = ram_en_q;
    assign ram_wr    = ram_wr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_dout  = ram_dout_q;
    assign done      = done_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign fault     = fault_q;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised byte-serial load/store unit for the MEM stage of the RISC-V core. It accepts one load/store request per transaction from EX through a valid/ready handshake. It sequences the request as single-byte accesses on the 8-bit memory-manager port and returns a sign- or zero-extended little-endian result to write-back. It holds the pipeline stall while a transaction is in flight and supports a configurable RAM read latency.

## Interface
Parameters:
- ADDR_W, 32, address width.
- XLEN, 32, data width; must be 32 (LW/SW use 4 bytes).
- RAM_LAT, 1, cycles from ram_addr presentation to valid ram_din; legal range 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  EX presents a memory op.
- req_ready  out  1  unit idle, can accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  XLEN  store data.
- req_rd  in  5  load destination register.
- ram_en  out  1  byte access valid this cycle.
- ram_wr  out  1  1 = write byte.
- ram_addr  out  ADDR_W  byte address.
- ram_dout  out  8  write byte.
- ram_din  in  8  read byte.
- done  out  1  one-cycle pulse at transaction end.
- wb_we  out  1  register write valid; qualified by done.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  load result.
- fault  out  1  misaligned fault; qualified by done; only when MEM_MISALIGN_TRAP_EN is defined.
- stall  out  1  holds IF/ID/EX while busy.

## Operation
- Reset values: req_ready=1, stall=0, ram_en=0, ram_wr=0, ram_addr=0, ram_dout=0, done=0, wb_we=0, wb_rd=0, wb_data=0, fault=0; FSM in IDLE.
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W. Unknown funct3 completes like a 1-byte load with wb_we=0.
- IDLE: req_ready=1. On req_valid&&req_ready, the unit latches op, addr, wdata and rd, goes to ISSUE, and sets stall=1 from the next cycle.
- ISSUE: issues byte k=0..N-1 in consecutive cycles with ram_addr=addr+k (ADDR_W modulo, wraps at top).
  - Stores drive ram_wr=1 and ram_dout=wdata[8k+7:8k], little-endian.
  - Loads drive ram_wr=0.
- After byte N-1:
  - Stores go to DONE.
  - Loads go to DRAIN.
- DRAIN (loads only): captures byte k from ram_din RAM_LAT cycles after its issue, into result[8k+7:8k]. It leaves DRAIN once the last byte is captured.
- DONE: done=1 for one cycle.
  - wb_we = load && rd!=0.
  - wb_data is the extended result: LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend.
  - Stores set wb_data=0.
- The unit returns to IDLE the next cycle. req_ready rises in the DONE cycle and stall falls in the DONE cycle, so back-to-back accept happens on the DONE edge.
- Outside ISSUE: ram_en=0 and ram_wr=0.
- Any request held while busy is ignored; EX keeps it asserted until it sees req_ready.
- rst mid-transaction: the transaction is aborted, all outputs go to reset values, and no done is produced. Partially written store bytes are not undone.

## Timing
Timing is relative to accept edge E0:
- Store: ram writes in cycles 1..N, done in cycle N+1.
- Load: issue in cycles 1..N, last capture in cycle N+RAM_LAT, done in cycle N+RAM_LAT+1.
- With RAM_LAT=1: LW takes 6 cycles accept-to-done, LB 3, SW 5, SB 2.
- stall is high from cycle 1 through cycle before done.

## Configuration
MEM_MISALIGN_TRAP_EN:
- Defined: a halfword with addr[0]!=0, or a word with addr[1:0]!=0, performs no RAM access. The unit goes directly to DONE in cycle 1 with fault=1, wb_we=0 and wb_data=0.
- Undefined: misaligned accesses complete byte-serially like aligned ones, and fault is tied 0.

## Structure
- Shared package mem_pkg holds:
  - funct3 constants (F3_LB..F3_SW);
  - the FSM enum (IDLE, ISSUE, DRAIN, DONE);
  - the byte-count function.
- Sub-module mem_lsu_ext: combinational extender. It maps funct3 plus the raw 32-bit assembled bytes to wb_data.
- RAM_LAT capture uses a RAM_LAT-deep shift register of {valid, byte index}.

## Test plan
- Reset, then idle: all outputs at reset values, req_ready=1, no ram_en.
- SW 0x11223344 to 0x100:
  - writes 0x44@0x100, 0x33@0x101, 0x22@0x102, 0x11@0x103 in cycles 1..4;
  - done in cycle 5, wb_we=0.
- Back-to-back loads from the bytes stored above, RAM_LAT=1:
  - LW 0x100 returns 0x11223344 in cycle 6;
  - LH 0x102 accepted on the same edge returns 0x00001122;
  - LB 0x103 from 0x80 data returns 0xFFFFFF80;
  - LBU 0x103 returns 0x00000080.
- RAM_LAT=3: LHU 0x100 with bytes 0x44,0x83 returns 0x00008344, done in cycle 6.
- Misaligned LW 0x101:
  - with macro: fault=1, done in cycle 1, no ram_en;
  - without macro: returns bytes 0x101..0x104 assembled little-endian.
- Edge cases:
  - rst asserted in cycle 2 of SW: no done, req_ready=1 next cycle.
  - LW to rd=0: done=1, wb_we=0.
